// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with alternating short/long bit periods feeding a first-word-fall-through FIFO; UART_RX_FRAMING_CHECK_EN enables stop-bit checking
module uart_receiver #(
  parameter int HALF_INTERVAL  = 520,
  parameter int INTERVAL_SHORT = 1041,
  parameter int INTERVAL_LONG  = 1042,
  parameter int FIFO_LOG2      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic       frame_error
);
  localparam int CW = $clog2((INTERVAL_LONG > HALF_INTERVAL ? INTERVAL_LONG : HALF_INTERVAL) + 1);
  localparam int DEPTH = 1 << FIFO_LOG2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_s, line_high, line_high_n, use_long, use_long_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic tick, stop_sample, stop_ok, push, pop, full, accept;
  logic [FIFO_LOG2:0] wptr, rptr;
  logic [7:0] mem [DEPTH];
  assign tick = cnt == '0;
  assign stop_sample = state == STOP && tick;
`ifdef UART_RX_FRAMING_CHECK_EN
  assign stop_ok = rx_s;
  // flag a stop bit that sampled low
  always_ff @(posedge clk) frame_error <= reset ? 1'b0 : stop_sample && !rx_s;
`else
  assign stop_ok = 1'b1;
  assign frame_error = 1'b0;
`endif
  assign push = stop_sample && stop_ok;
  assign full = (wptr ^ rptr) == {1'b1, {FIFO_LOG2{1'b0}}};
  assign out_valid = wptr != rptr;
  assign pop = out_valid && out_ready;
  assign accept = push && (!full || pop);
  assign out_data = out_valid ? mem[rptr[FIFO_LOG2-1:0]] : 8'h00;
  // next state, bit timing, alternating period select and LSB-first shift
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? cnt : cnt - 1'b1;
    idx_n = idx;
    shift_n = shift;
    use_long_n = use_long;
    line_high_n = line_high;
    if (state == IDLE) begin
      line_high_n = line_high | rx_s;
      if (!rx_s && line_high) begin
        state_n = START;
        line_high_n = 1'b0;
        use_long_n = 1'b0;
        cnt_n = CW'(HALF_INTERVAL - 1);
      end
    end else if (tick) begin
      cnt_n = use_long ? CW'(INTERVAL_LONG - 1) : CW'(INTERVAL_SHORT - 1);
      use_long_n = !use_long;
      if (state == START) begin
        state_n = rx_s ? IDLE : DATA;
        idx_n = '0;
      end else if (state == DATA) begin
        shift_n = {rx_s, shift[7:1]};
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end else begin
        state_n = IDLE;
      end
    end
  end
  // receiver state, input synchroniser and overrun pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rx_s <= 1'b1;
      line_high <= 1'b0;
      use_long <= 1'b0;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      rx_s <= uart_rx;
      line_high <= line_high_n;
      use_long <= use_long_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      overrun <= push && full && !pop;
    end
  end
  // receive FIFO; a full FIFO still accepts when the head is popped in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept) begin
        mem[wptr[FIFO_LOG2-1:0]] <= shift;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random frames against a queue-based reference of the received byte stream
module tb_uart_receiver;
  localparam int H = 8, SH = 16, LG = 17, LOG2 = 4;
  localparam int FRAME = 5 * (SH + LG);
  localparam int STOP_TICK = 2 + H + 5 * SH + 4 * LG;
  logic clk = 0, reset = 1, uart_rx = 1, out_ready = 0;
  logic [7:0] out_data;
  logic out_valid, overrun, frame_error;
  int total = 0, bad = 0, vcnt = 0, ovr = 0, fe = 0;
  int g0, v0, o0, f0;
  bit rnd_ready = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] d;

  uart_receiver #(.HALF_INTERVAL(H), .INTERVAL_SHORT(SH), .INTERVAL_LONG(LG), .FIFO_LOG2(LOG2)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .frame_error(frame_error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (out_valid) vcnt++;
    if (overrun) ovr++;
    if (frame_error) fe++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(int n);
    uart_rx = 1;
    repeat (n) tick();
  endtask

  task automatic send(logic [7:0] b, logic stop = 1, int pop_at = -1, int rst_at = -1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < FRAME; c++) begin
      uart_rx = f[4'((2 * c + 1) / (SH + LG))];
      if (pop_at >= 0) out_ready = (c == pop_at);
      reset = (c == rst_at);
      tick();
    end
  endtask

  task automatic mark();
    g0 = got.size();
    v0 = vcnt;
    o0 = ovr;
    f0 = fe;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(string tag);
    chk({tag, "_count"}, got.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (g0 + i < got.size()) ? {24'h0, got[g0 + i]} : 32'hx, {24'h0, exp_q[i]});
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_error", frame_error, 0);
    reset = 0;
    out_ready = 1;
    idle(5);
    mark();
    exp_q = '{8'hA5};
    send(8'hA5);
    idle(20);
    chk_q("a5_byte");
    chk("a5_valid_cycles", vcnt - v0, 1);
    chk("a5_overrun", ovr - o0, 0);
    chk("a5_frame_error", fe - f0, 0);
    mark();
    uart_rx = 0;
    repeat (H / 2) tick();
    idle(60);
    chk("glitch_valid", out_valid, 0);
    chk("glitch_bytes", got.size() - g0, 0);
    chk("glitch_valid_cycles", vcnt - v0, 0);
    mark();
    exp_q.delete();
    rnd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send(d);
      idle($urandom_range(1, 8));
    end
    rnd_ready = 0;
    out_ready = 1;
    idle(10);
    chk_q("rand_byte");
    chk("rand_overrun", ovr - o0, 0);
    out_ready = 0;
    mark();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send(8'(i));
      idle(3);
    end
    chk("ovr_pulses", ovr - o0, 1);
    chk("ovr_full_valid", out_valid, 1);
    out_ready = 1;
    idle(20);
    chk_q("ovr_drain");
    chk("ovr_drained_valid", out_valid, 0);
    out_ready = 0;
    mark();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i));
      idle(3);
    end
    exp_q.push_back(8'h10);
    send(8'h10, 1, STOP_TICK - 1);
    idle(3);
    chk("popfull_overrun", ovr - o0, 0);
    chk("popfull_one_popped", got.size() - g0, 1);
    out_ready = 1;
    idle(25);
    chk_q("popfull_drain");
    chk("popfull_drained_valid", out_valid, 0);
    mark();
`ifdef UART_RX_FRAMING_CHECK_EN
    exp_q = '{8'h3C};
`else
    exp_q = '{8'h3C, 8'h3C};
`endif
    send(8'h3C, 0);
    repeat (300) tick();
    chk("framing_held_low_bytes", got.size() - g0, exp_q.size() - 1);
    idle(20);
    send(8'h3C);
    idle(20);
    chk_q("framing_byte");
`ifdef UART_RX_FRAMING_CHECK_EN
    chk("framing_error_pulses", fe - f0, 1);
`else
    chk("framing_error_pulses", fe - f0, 0);
`endif
    chk("framing_overrun", ovr - o0, 0);
    mark();
    send(8'hFF, 1, -1, 90);
    idle(5);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_bytes", got.size() - g0, 0);
    mark();
    exp_q = '{8'h12};
    send(8'h12);
    idle(20);
    chk_q("midrst_next");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter HALF_INTERVAL, default 520, meaning cycles from start-bit detection to the start-bit sample point.
REQ-002 SHALL have parameter INTERVAL_SHORT, default 1041, meaning the shorter bit period in cycles.
REQ-003 SHALL have parameter INTERVAL_LONG, default 1042, meaning the longer bit period in cycles.
REQ-004 SHALL have parameter FIFO_LOG2, default 4, meaning log2 of the receive FIFO depth (depth 16).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port uart_rx, input, 1 bit: serial line, idle high, already registered once upstream.
REQ-008 SHALL have port out_data, output, 8 bits: the byte at the FIFO head.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid && out_ready.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-012 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a stop bit samples 0.

Function
REQ-013 SHALL pass uart_rx through one additional flop (rx_s); all decisions use rx_s.
REQ-014 SHALL implement states IDLE, START, DATA and STOP.
REQ-015 IDLE: when rx_s==0 and the line-high flag is set, SHALL go to START and load the counter so that the start sample occurs HALF_INTERVAL cycles later.
REQ-016 START sample: if rx_s==1 (glitch), SHALL return to IDLE with no output; otherwise SHALL go to DATA.
REQ-017 DATA SHALL take 8 samples, LSB first, spaced one bit period apart; then STOP samples one bit period after the 8th data sample.
REQ-018 Bit periods SHALL alternate INTERVAL_SHORT, INTERVAL_LONG, INTERVAL_SHORT, ..., starting with SHORT for the first data bit, over all 9 post-start intervals.
REQ-019 The line-high flag SHALL be set by any cycle in IDLE with rx_s==1, and SHALL be cleared on leaving IDLE, so a held-low line never retriggers.
REQ-020 STOP sample SHALL always return to IDLE in the same cycle, and SHALL push the byte into the FIFO unless it is dropped per REQ-031/REQ-022.
REQ-021 A pushed byte SHALL appear on out_data/out_valid on the cycle after the stop sample when the FIFO was empty (first-word fall-through).
REQ-022 Push while full with no pop in the same cycle: SHALL drop the byte, leave the FIFO unchanged and pulse overrun.
REQ-023 Push while full with a pop in the same cycle: SHALL accept the byte with no overrun.
REQ-024 Pop and push on an empty FIFO are not simultaneous, since out_valid==0; out_ready while empty SHALL be ignored.
REQ-025 Read and write pointers SHALL be FIFO_LOG2+1 bits wide and wrap modulo 2*depth; full means the MSBs differ and the low bits are equal.

Reset
REQ-026 Reset SHALL force IDLE, clear the line-high flag and set rx_s=1.
REQ-027 Reset SHALL empty the FIFO; on the following cycle out_valid=0, out_data=0, overrun=0 and frame_error=0.
REQ-028 Reset asserted mid-frame SHALL abandon the partial byte, which is never pushed.

Configuration
REQ-029 Macro UART_RX_FRAMING_CHECK_EN SHALL select stop-bit checking.
REQ-030 With UART_RX_FRAMING_CHECK_EN defined, a stop sample of 0 SHALL pulse frame_error.
REQ-031 With UART_RX_FRAMING_CHECK_EN defined, a stop sample of 0 SHALL discard the byte, which is not pushed and cannot cause overrun.
REQ-032 Without UART_RX_FRAMING_CHECK_EN, the stop value SHALL be ignored, every byte SHALL be pushed, and frame_error SHALL be constant 0.

Verification
REQ-033 Default parameters, send 0xA5 at 1041.67 cycles/bit, out_ready=1 -> exactly one out_valid cycle carrying out_data=0xA5, with no overrun and no frame_error.
REQ-034 A 300-cycle low glitch on idle rx -> no state beyond START, out_valid remains 0.
REQ-035 Send 17 bytes 0x00..0x10 with out_ready=0 -> overrun pulses once on the 17th byte; then draining yields 0x00..0x0F in order and out_valid falls.
REQ-036 FIFO full, and the 17th stop sample coincides with out_ready=1 -> no overrun; the drain yields 0x01..0x10.
REQ-037 With the macro defined, send 0x3C with stop=0 and the line held low for 5000 cycles -> frame_error pulses once, nothing is pushed, and no new frame starts until the line goes high; a subsequent 0x3C is received correctly.
REQ-038 Assert reset for 1 cycle midway through bit 4 of 0xFF -> out_valid=0; the next full frame 0x12 is received as 0x12.
